// File: rtl/icache_pkg.sv
// Shared types and geometry helpers for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned ADDR_BITS        = 32;
  localparam int unsigned BYTE_OFFSET_BITS = 2;

  function automatic int unsigned offset_bits(input int unsigned words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int unsigned index_bits(input int unsigned num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int unsigned tag_bits(input int unsigned num_lines,
                                           input int unsigned words_per_line);
    return ADDR_BITS - BYTE_OFFSET_BITS - offset_bits(words_per_line) - index_bits(num_lines);
  endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for icache_direct: combinational read, synchronous
// word and tag writes, synchronous clear of every valid bit on rst.
module icache_array
  import icache_pkg::*;
#(
  parameter int NUM_LINES      = 16,
  parameter int WORDS_PER_LINE = 4,
  localparam int OB = offset_bits(WORDS_PER_LINE),
  localparam int IB = index_bits(NUM_LINES),
  localparam int TB = tag_bits(NUM_LINES, WORDS_PER_LINE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IB-1:0] rd_index,
  input  logic [OB-1:0] rd_offset,
  output logic          rd_valid,
  output logic [TB-1:0] rd_tag,
  output logic [31:0]   rd_data,
  input  logic          wr_en,
  input  logic [IB-1:0] wr_index,
  input  logic [OB-1:0] wr_offset,
  input  logic [31:0]   wr_data,
  input  logic          tag_wr_en,
  input  logic [TB-1:0] tag_wr
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TB-1:0]        tag_mem  [NUM_LINES];
  logic [31:0]          data_mem [NUM_LINES*WORDS_PER_LINE];

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (tag_wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // NOTE: tag and data arrays carry no reset; the valid bits alone decide
  // whether their contents mean anything, so they can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (tag_wr_en) tag_mem[wr_index] <= tag_wr;
    if (wr_en)     data_mem[{wr_index, wr_offset}] <= wr_data;
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[{rd_index, rd_offset}];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache with word-at-a-time line refill.
// Define ICACHE_STATS_EN to add the stat_hits / stat_misses counters.
module icache_direct
  import icache_pkg::*;
#(
  parameter int NUM_LINES      = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imemreq_val,
  input  logic [31:0] imemreq_addr,
  output logic        imemresp_val,
  output logic [31:0] imemresp_data,
  output logic        memreq_val,
  input  logic        memreq_rdy,
  output logic [31:0] memreq_addr,
  input  logic        memresp_val,
  input  logic [31:0] memresp_data
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses
`endif
);

  localparam int OB = offset_bits(WORDS_PER_LINE);
  localparam int IB = index_bits(NUM_LINES);
  localparam int TB = tag_bits(NUM_LINES, WORDS_PER_LINE);

  state_t        state;
  logic [TB-1:0] miss_tag;
  logic [IB-1:0] miss_index;
  logic [OB-1:0] word_cnt;
  logic [OB-1:0] next_cnt;

  logic [OB-1:0] req_offset;
  logic [IB-1:0] req_index;
  logic [TB-1:0] req_tag;
  logic          unused_byte_bits;

  logic          rd_valid;
  logic [TB-1:0] rd_tag;
  logic          lookup_hit;
  logic          miss;
  logic          last_word;
  logic          refill_wr;

  assign req_offset       = imemreq_addr[OB+1:2];
  assign req_index        = imemreq_addr[IB+OB+1:OB+2];
  assign req_tag          = imemreq_addr[31:IB+OB+2];
  assign unused_byte_bits = ^imemreq_addr[1:0];

  assign lookup_hit   = rd_valid && (rd_tag == req_tag);
  assign imemresp_val = (state == IDLE) && imemreq_val && lookup_hit;
  assign miss         = (state == IDLE) && imemreq_val && !lookup_hit;

  assign next_cnt  = word_cnt + OB'(1);
  assign last_word = (word_cnt == OB'(WORDS_PER_LINE - 1));
  // Responses outside RESP, or in the reset cycle, never touch the arrays.
  assign refill_wr = (state == RESP) && memresp_val && !rst;

  icache_array #(
    .NUM_LINES      (NUM_LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .rd_index  (req_index),
    .rd_offset (req_offset),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_data   (imemresp_data),
    .wr_en     (refill_wr),
    .wr_index  (miss_index),
    .wr_offset (word_cnt),
    .wr_data   (memresp_data),
    .tag_wr_en (refill_wr && last_word),
    .tag_wr    (miss_tag)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      word_cnt    <= '0;
      memreq_val  <= 1'b0;
      memreq_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss) begin
            state       <= REQ;
            word_cnt    <= '0;
            memreq_val  <= 1'b1;
            memreq_addr <= {req_tag, req_index, {OB{1'b0}}, 2'b00};
          end
        end
        REQ: begin
          if (memreq_rdy) begin
            state       <= RESP;
            memreq_val  <= 1'b0;
            memreq_addr <= '0;
          end
        end
        RESP: begin
          if (memresp_val) begin
            if (last_word) begin
              state <= IDLE;
            end else begin
              state       <= REQ;
              word_cnt    <= next_cnt;
              memreq_val  <= 1'b1;
              memreq_addr <= {miss_tag, miss_index, next_cnt, 2'b00};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The miss line is held for the whole refill, whatever the processor does.
  always_ff @(posedge clk) begin
    if (miss) begin
      miss_tag   <= req_tag;
      miss_index <= req_index;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else begin
      if (imemresp_val) stat_hits   <= stat_hits + 32'd1;
      if (miss)         stat_misses <= stat_misses + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: directed scenarios, then random fetches
// checked against a line-address model where cached data always equals memory.
module tb_icache_direct;

  localparam int N_LINES    = 16;
  localparam int WPL        = 4;
  localparam int LINE_BYTES = WPL * 4;

  logic        clk;
  logic        rst;
  logic        imemreq_val;
  logic [31:0] imemreq_addr;
  logic        imemresp_val;
  logic [31:0] imemresp_data;
  logic        memreq_val;
  logic        memreq_rdy;
  logic [31:0] memreq_addr;
  logic        memresp_val;
  logic [31:0] memresp_data;
`ifdef ICACHE_STATS_EN
  logic [31:0] stat_hits;
  logic [31:0] stat_misses;
`endif

  icache_direct #(
    .NUM_LINES      (N_LINES),
    .WORDS_PER_LINE (WPL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imemreq_val   (imemreq_val),
    .imemreq_addr  (imemreq_addr),
    .imemresp_val  (imemresp_val),
    .imemresp_data (imemresp_data),
    .memreq_val    (memreq_val),
    .memreq_rdy    (memreq_rdy),
    .memreq_addr   (memreq_addr),
    .memresp_val   (memresp_val),
    .memresp_data  (memresp_data)
`ifdef ICACHE_STATS_EN
    ,
    .stat_hits     (stat_hits),
    .stat_misses   (stat_misses)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Backing memory contents, created on first touch.
  logic [31:0] mem [int unsigned];
  // Cache model: which line-aligned address each index currently holds.
  bit          line_valid [N_LINES];
  logic [31:0] line_base  [N_LINES];
  int          exp_hits   = 0;
  int          exp_misses = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic int line_index(input logic [31:0] a);
    return int'((a / LINE_BYTES) % N_LINES);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < N_LINES; i++) line_valid[i] = 0;
  endtask

  // One fetch: a single hit cycle, or a miss followed by a full refill and the
  // hit that returns once the line is valid. Stalls/delays apply at stall_word.
  task automatic fetch(input logic [31:0] addr, input int stall_word,
                       input int stalls, input int delays);
    int          idx;
    logic [31:0] base;
    logic [31:0] exp_a;
    idx  = line_index(addr);
    base = addr & ~32'(LINE_BYTES - 1);
    imemreq_val  = 1'b1;
    imemreq_addr = addr;
    memresp_val  = 1'b0;
    #1;
    if (line_valid[idx] && line_base[idx] == base) begin
      check("hit_val", imemresp_val, 1);
      check("hit_data", imemresp_data, mem_rd(addr & ~32'd3));
      check("hit_no_memreq", memreq_val, 0);
      exp_hits++;
      next_cycle();
    end else begin
      check("miss_val", imemresp_val, 0);
      check("miss_no_memreq", memreq_val, 0);
      exp_misses++;
      next_cycle();
      for (int k = 0; k < WPL; k++) begin
        exp_a = base + 32'(4 * k);
        imemreq_val  = 1'($urandom);
        imemreq_addr = $urandom;
        for (int s = 0; s < ((k == stall_word) ? stalls : 0); s++) begin
          memreq_rdy = 1'b0;
          #1;
          check("stall_memreq_val", memreq_val, 1);
          check("stall_memreq_addr", memreq_addr, exp_a);
          check("stall_no_resp", imemresp_val, 0);
          next_cycle();
        end
        memreq_rdy = 1'b1;
        #1;
        check("req_val", memreq_val, 1);
        check("req_addr", memreq_addr, exp_a);
        check("req_no_resp", imemresp_val, 0);
        next_cycle();
        memreq_rdy = 1'($urandom);
        for (int d = 0; d < ((k == stall_word) ? delays : 0); d++) begin
          memresp_val  = 1'b0;
          memresp_data = $urandom;
          #1;
          check("wait_no_memreq", memreq_val, 0);
          check("wait_no_resp", imemresp_val, 0);
          next_cycle();
        end
        memresp_val  = 1'b1;
        memresp_data = mem_rd(exp_a);
        #1;
        check("resp_no_memreq", memreq_val, 0);
        check("resp_addr_zero", memreq_addr, 0);
        check("resp_no_resp", imemresp_val, 0);
        next_cycle();
        memresp_val = 1'b0;
        memreq_rdy  = 1'b0;
      end
      line_valid[idx] = 1;
      line_base[idx]  = base;
      imemreq_val  = 1'b1;
      imemreq_addr = addr;
      #1;
      check("refill_hit_val", imemresp_val, 1);
      check("refill_hit_data", imemresp_data, mem_rd(addr & ~32'd3));
      check("refill_idle_no_memreq", memreq_val, 0);
      exp_hits++;
      next_cycle();
    end
    imemreq_val = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    rst          = 1'b1;
    imemreq_val  = 1'b1;
    imemreq_addr = 32'h0;
    memreq_rdy   = 1'b0;
    memresp_val  = 1'b0;
    memresp_data = 32'h0;
    clear_model();
    next_cycle();
    next_cycle();
    check("rst_resp_val", imemresp_val, 0);
    check("rst_memreq_val", memreq_val, 0);
    check("rst_memreq_addr", memreq_addr, 0);
`ifdef ICACHE_STATS_EN
    check("rst_stat_hits", stat_hits, 0);
    check("rst_stat_misses", stat_misses, 0);
`endif
    rst = 1'b0;

    // Directed fill of line 0 and sequential hits across it.
    mem[32'h00] = 32'h11;
    mem[32'h04] = 32'h22;
    mem[32'h08] = 32'h33;
    mem[32'h0C] = 32'h44;
    fetch(32'h00, 0, 0, 0);
    fetch(32'h04, 0, 0, 0);
    fetch(32'h08, 0, 0, 0);
    fetch(32'h0C, 0, 0, 0);
    check("line0_word3", mem_rd(32'h0C), 32'h44);

    // Conflict on index 0, then the evicted line misses again.
    fetch(32'h100, 0, 0, 0);
    fetch(32'h00, 0, 0, 0);
`ifdef ICACHE_STATS_EN
    check("stat_misses_directed", stat_misses, 32'(exp_misses));
    check("stat_hits_directed", stat_hits, 32'(exp_hits));
`endif

    // Memory back-pressure: 3 refused cycles and 2 late-response cycles at word 1.
    fetch(32'h204, 1, 3, 2);

    // Stray response in IDLE must not overwrite the line just filled.
    imemreq_val  = 1'b0;
    memresp_val  = 1'b1;
    memresp_data = ~mem_rd(32'h20C);
    #1;
    check("stray_no_memreq", memreq_val, 0);
    next_cycle();
    memresp_val = 1'b0;
    fetch(32'h20C, 0, 0, 0);

    // Reset in RESP of word 2 abandons the refill; the next fetch restarts it.
    imemreq_val  = 1'b1;
    imemreq_addr = 32'h308;
    #1;
    check("abort_miss", imemresp_val, 0);
    next_cycle();
    imemreq_val = 1'b0;
    for (int k = 0; k < 3; k++) begin
      memreq_rdy = 1'b1;
      #1;
      check("abort_req_addr", memreq_addr, 32'h300 + 32'(4 * k));
      next_cycle();
      memreq_rdy = 1'b0;
      if (k < 2) begin
        memresp_val  = 1'b1;
        memresp_data = mem_rd(32'h300 + 32'(4 * k));
        next_cycle();
        memresp_val = 1'b0;
      end
    end
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    clear_model();
    exp_hits   = 0;
    exp_misses = 0;
    memresp_val  = 1'b1;
    memresp_data = $urandom;
    #1;
    check("post_rst_memreq_val", memreq_val, 0);
    check("post_rst_memreq_addr", memreq_addr, 0);
    next_cycle();
    memresp_val = 1'b0;
    fetch(32'h308, 0, 0, 0);
    fetch(32'h300, 0, 0, 0);

    // Random fetches over four tags so hits, misses and evictions all recur.
    for (int i = 0; i < 80; i++) begin
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, N_LINES - 1)) << 4)
        | (32'($urandom_range(0, WPL - 1)) << 2) | 32'($urandom_range(0, 3));
      fetch(a, $urandom_range(0, WPL - 1), $urandom_range(0, 2), $urandom_range(0, 2));
    end

`ifdef ICACHE_STATS_EN
    check("stat_hits_final", stat_hits, 32'(exp_hits));
    check("stat_misses_final", stat_misses, 32'(exp_misses));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icache_direct.md
# icache_direct

Direct-mapped, read-only instruction cache that sits directly upstream of the processor datapath's fetch stage. It answers fetch requests from the processor in the same cycle on a hit. On a miss it stalls the processor and refills one full line from the backing memory, issuing one word request at a time. The processor's control unit uses `imemresp_val` to hold the F/D pipeline registers while a refill is in progress.

## Interface
Parameters:
- `NUM_LINES`, 16, number of cache lines (power of two, ≥2)
- `WORDS_PER_LINE`, 4, 32-bit words per line (power of two, ≥2)

Ports:
- `clk`  in  1  clock; single clock domain, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `imemreq_val`  in  1  processor fetch request valid
- `imemreq_addr`  in  32  fetch byte address; bits [1:0] ignored
- `imemresp_val`  out  1  fetch data valid this cycle (hit)
- `imemresp_data`  out  32  fetched instruction word
- `memreq_val`  out  1  memory word-read request valid
- `memreq_rdy`  in  1  memory accepts request
- `memreq_addr`  out  32  word-aligned byte address of requested word
- `memresp_val`  in  1  memory response valid
- `memresp_data`  in  32  memory response word
- `stat_hits`, `stat_misses`  out  32 each  present only with `ICACHE_STATS_EN`

## Operation
- Address split: offset = addr[OB+1:2], index = addr[IB+OB+1:OB+2], tag = remaining upper bits. OB = log2(WORDS_PER_LINE), IB = log2(NUM_LINES). Defaults: offset [3:2], index [7:4], tag [31:8].
- Storage per line: valid bit, tag, WORDS_PER_LINE data words.
- Hit: state IDLE, `imemreq_val`=1, line valid, and tag matches. `imemresp_val`=1 combinationally in the same cycle.
- `imemresp_data` always reflects the data word selected by the current index/offset, whether or not the access is valid.
- FSM states:
  - IDLE: on `imemreq_val` with a miss, latch tag and index, clear the word counter, and go to REQ. No memory traffic.
  - REQ: `memreq_val`=1 and `memreq_addr` = {latched tag, latched index, counter, 2'b00}. Go to RESP when `memreq_rdy`=1; otherwise stay in REQ.
  - RESP: on `memresp_val`, write `memresp_data` to word [counter] of the latched line.
    - If counter == WORDS_PER_LINE-1: write the tag, set valid, and go to IDLE.
    - Otherwise: increment counter and go to REQ.
- `imemresp_val`=0 in REQ and RESP.
- After returning to IDLE, the lookup uses the current `imemreq_addr`; no data is forwarded from the refill.
- Only one memory request is outstanding at a time.
- `memresp_val` outside RESP is ignored.
- If `imemreq_addr` changes mid-refill, the refill still completes for the latched line.
- Refill replaces the indexed line unconditionally. No dirty state is kept.
- Reset:
  - All valid bits cleared, state = IDLE, counter = 0.
  - `imemresp_val`=0, `memreq_val`=0, `memreq_addr`=0 (address is 0 whenever not in REQ).
  - Data and tag arrays are not reset.
  - Reset during a refill abandons it; the line stays invalid, and a late `memresp_val` after reset is ignored.

## Timing
- Hit latency is 0 cycles (combinational lookup).
- Miss penalty with `memreq_rdy`=1 and response one cycle after acceptance:
  - Miss detected in cycle 0.
  - Word k is requested in cycle 1+2k and written in cycle 2+2k.
  - Line is valid in IDLE at cycle 2·WORDS_PER_LINE+1: cycle 9 at the default, where the hit returns.
- Each cycle `memreq_rdy`=0 in REQ, or `memresp_val`=0 in RESP, adds one cycle.
- Array writes take effect at the end of the cycle. A lookup in the same cycle sees the old contents.

## Configuration
- `ICACHE_STATS_EN` defined:
  - `stat_hits` increments on every IDLE cycle with `imemreq_val` and a hit.
  - `stat_misses` increments once per miss, on the IDLE→REQ transition.
  - Both reset to 0 and wrap modulo 2^32.
- `ICACHE_STATS_EN` undefined: ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package `icache_pkg`: FSM state typedef (IDLE, REQ, RESP) and width helper constants for offset, index and tag derived from the parameters.
- One sub-module `icache_array`:
  - Valid, tag and data storage.
  - Combinational read by index/offset.
  - Synchronous word write, plus tag/valid write.
  - Synchronous clear of all valid bits on `rst`.
- Top level holds the FSM, latched miss address, word counter and optional statistics counters.

## Test plan
- After reset, fetch 0x00000000: `imemresp_val`=0 in cycle 0, and `memreq_addr` 0x00, 0x04, 0x08, 0x0C in sequence. Memory returns 0x11,0x22,0x33,0x44; hit in cycle 9 with data 0x11.
- Then fetch 0x04, 0x08, 0x0C on consecutive cycles: hits, data 0x22, 0x33, 0x44, and no `memreq_val`.
- Fetch 0x100 (same index 0, different tag): miss, refill from 0x100–0x10C, then 0x100 hits with the new data. A re-fetch of 0x00 misses again.
- Hold `memreq_rdy`=0 for 3 cycles at word 1 and delay `memresp_val` by 2 cycles: the address stays stable, total penalty is 14 cycles, and the data is correct.
- Assert `rst` in RESP of word 2, then fetch the same address: full 4-word refill restarts from word 0. A stray `memresp_val` while in IDLE causes no array write.
- With `ICACHE_STATS_EN`: the first three scenarios yield `stat_misses`=3 (0x00, 0x100, 0x00) and `stat_hits`=5 (0x00, 0x04, 0x08, 0x0C, 0x100), excluding the final re-fetch hit of 0x00.
